// File: rtl/fix_field_parser.sv
// fix_field_parser: splits an ASCII FIX byte stream (tag '=' value SOH) into
// a binary tag plus a valid/ready stream of value bytes with a last marker.
// A one-byte hold register keeps the newest value byte back until its
// successor (or SOH) arrives, so the final byte can be flagged with last.
// Optional build macro FIX_CHECKSUM_EN adds the tag-10 checksum check;
// without it chk_done and chk_ok are tied low.
module fix_field_parser #(
    parameter int TAG_W       = 16,
    parameter int MAX_VAL_LEN = 32,
    parameter int LEN_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       din,
    input  logic             ready,
    output logic             in_ready,
    output logic [7:0]       dout,
    output logic             valid,
    output logic             last,
    output logic [TAG_W-1:0] tag,
    output logic             tag_valid,
    output logic [LEN_W-1:0] field_len,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             chk_done,
    output logic             chk_ok
);

    localparam logic [7:0] SOH   = 8'h01;
    localparam logic [7:0] EQ    = 8'h3D;
    // Four extra bits cover acc*10+9 for any in-range accumulator value.
    localparam int         ACC_W = TAG_W + 4;

    typedef enum logic [1:0] {
        S_TAG,
        S_VALUE,
        S_SKIP
    } state_t;

    state_t             state_reg;
    logic [TAG_W-1:0]   tag_acc_reg;
    logic               tag_seen_reg;   // at least one tag digit received
    logic               tag_ovf_reg;    // tag exceeded 2**TAG_W-1 (sticky)
    logic [7:0]         hold_reg;
    logic               hold_full_reg;
    logic [LEN_W-1:0]   cnt_reg;
    logic [7:0]         dout_reg;
    logic               valid_reg;
    logic               last_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               tag_valid_reg;
    logic [LEN_W-1:0]   field_len_reg;
    logic               err_reg;
    logic [1:0]         err_code_reg;

    logic               accept;
    logic               is_digit;
    logic               is_soh;
    logic [ACC_W-1:0]   acc_ext;
    logic               acc_over;

    // A byte may enter whenever the output slot is empty or draining this cycle.
    assign in_ready = !valid_reg || ready;
    assign accept   = enable && in_ready;
    assign is_digit = (din >= 8'h30) && (din <= 8'h39);
    assign is_soh   = (din == SOH);
    assign acc_ext  = ACC_W'(tag_acc_reg) * ACC_W'(10) + ACC_W'(din[3:0]);
    assign acc_over = |acc_ext[ACC_W-1:TAG_W];

    assign dout      = dout_reg;
    assign valid     = valid_reg;
    assign last      = last_reg;
    assign tag       = tag_reg;
    assign tag_valid = tag_valid_reg;
    assign field_len = field_len_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

    // Parser FSM with registered outputs, hold register and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_TAG;
            tag_acc_reg   <= '0;
            tag_seen_reg  <= 1'b0;
            tag_ovf_reg   <= 1'b0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            cnt_reg       <= '0;
            dout_reg      <= '0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
            tag_reg       <= '0;
            tag_valid_reg <= 1'b0;
            field_len_reg <= '0;
            err_reg       <= 1'b0;
            err_code_reg  <= 2'd0;
        end else begin
            tag_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= 2'd0;
            // Beat consumed; a new beat loaded below overrides this clear.
            if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
            if (accept) begin
                case (state_reg)
                    S_TAG: begin
                        if (is_digit) begin
                            tag_seen_reg <= 1'b1;
                            if (!tag_ovf_reg) begin
                                if (acc_over) begin
                                    tag_ovf_reg <= 1'b1;
                                end else begin
                                    tag_acc_reg <= acc_ext[TAG_W-1:0];
                                end
                            end
                        end else begin
                            tag_acc_reg  <= '0;
                            tag_seen_reg <= 1'b0;
                            tag_ovf_reg  <= 1'b0;
                            if (din == EQ && tag_seen_reg && !tag_ovf_reg) begin
                                tag_reg       <= tag_acc_reg;
                                tag_valid_reg <= 1'b1;
                                cnt_reg       <= '0;
                                hold_full_reg <= 1'b0;
                                state_reg     <= S_VALUE;
                            end else begin
                                err_reg      <= 1'b1;
                                err_code_reg <= (din == EQ) ? 2'd2 : 2'd1;
                                state_reg    <= S_SKIP;
                            end
                        end
                    end
                    S_VALUE: begin
                        if (is_soh) begin
                            // Empty value: nothing held, so no beat at all.
                            if (hold_full_reg) begin
                                dout_reg      <= hold_reg;
                                valid_reg     <= 1'b1;
                                last_reg      <= 1'b1;
                                field_len_reg <= cnt_reg;
                            end
                            hold_full_reg <= 1'b0;
                            state_reg     <= S_TAG;
                        end else if (cnt_reg == LEN_W'(MAX_VAL_LEN)) begin
                            // Too long: drop this byte and the held one, no last beat.
                            hold_full_reg <= 1'b0;
                            err_reg       <= 1'b1;
                            err_code_reg  <= 2'd3;
                            state_reg     <= S_SKIP;
                        end else begin
                            if (hold_full_reg) begin
                                dout_reg  <= hold_reg;
                                valid_reg <= 1'b1;
                                last_reg  <= 1'b0;
                            end
                            hold_reg      <= din;
                            hold_full_reg <= 1'b1;
                            cnt_reg       <= cnt_reg + LEN_W'(1);
                        end
                    end
                    default: begin
                        if (is_soh) begin
                            state_reg <= S_TAG;
                        end
                    end
                endcase
            end
        end
    end

`ifdef FIX_CHECKSUM_EN
    logic [7:0]  sum_reg;
    logic [7:0]  snap_reg;
    logic [15:0] chk_val_reg;
    logic        mid_field_reg;   // a byte of the current field was already seen
    logic        chk_done_reg;
    logic        chk_ok_reg;
    logic        in_tag10;

    assign in_tag10 = (state_reg == S_VALUE) && (tag_reg == TAG_W'(10));
    assign chk_done = chk_done_reg;
    assign chk_ok   = chk_ok_reg;

    // Running byte sum, per-field snapshot and tag-10 value comparison.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_reg       <= '0;
            snap_reg      <= '0;
            chk_val_reg   <= '0;
            mid_field_reg <= 1'b0;
            chk_done_reg  <= 1'b0;
            chk_ok_reg    <= 1'b0;
        end else begin
            chk_done_reg <= 1'b0;
            chk_ok_reg   <= 1'b0;
            if (accept) begin
                if (!mid_field_reg) begin
                    snap_reg <= sum_reg;
                end
                mid_field_reg <= !is_soh;
                sum_reg       <= sum_reg + din;
                if (!in_tag10) begin
                    chk_val_reg <= '0;
                end else if (is_soh) begin
                    // Result pulse rides with the final beat of the tag-10 value.
                    if (hold_full_reg) begin
                        chk_done_reg <= 1'b1;
                        chk_ok_reg   <= (chk_val_reg == {8'd0, snap_reg});
                    end
                    chk_val_reg <= '0;
                    sum_reg     <= '0;
                end else if (is_digit) begin
                    chk_val_reg <= chk_val_reg * 16'd10 + 16'(din[3:0]);
                end
            end
        end
    end
`else
    assign chk_done = 1'b0;
    assign chk_ok   = 1'b0;
`endif

endmodule

// File: tb/tb_fix_field_parser.sv
// Testbench for fix_field_parser: directed fields plus randomized field
// streams under random enable/ready, checked against a field-level model.
module tb_fix_field_parser;

    localparam int TAG_W = 16;
    localparam int MAXV  = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [7:0]       din;
    logic             ready;
    logic             in_ready;
    logic [7:0]       dout;
    logic             valid;
    logic             last;
    logic [TAG_W-1:0] tag;
    logic             tag_valid;
    logic [LEN_W-1:0] field_len;
    logic             err;
    logic [1:0]       err_code;
    logic             chk_done;
    logic             chk_ok;

    always #5 clk = ~clk;

    fix_field_parser #(
        .TAG_W(TAG_W),
        .MAX_VAL_LEN(MAXV),
        .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .din(din),
        .ready(ready),
        .in_ready(in_ready),
        .dout(dout),
        .valid(valid),
        .last(last),
        .tag(tag),
        .tag_valid(tag_valid),
        .field_len(field_len),
        .err(err),
        .err_code(err_code),
        .chk_done(chk_done),
        .chk_ok(chk_ok)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         tag;
        int         len;
    } beat_t;

    beat_t      exp_beats[$];
    int         exp_tags[$];
    int         exp_errs[$];
    int         exp_chk[$];
    logic [7:0] in_q[$];
    bit         skip_carry = 1'b0;
    int         ready_pct  = 100;
    int         en_pct     = 100;
    int         n_checks   = 0;
    int         n_errors   = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, obs, exp);
        end
    endtask

    // Field-level reference: one SOH-terminated segment at a time.
    task automatic send_seg(input logic [7:0] seg[$]);
        int     i = 0;
        longint num = 0;
        int     vlen;
        beat_t  b;
        foreach (seg[k]) in_q.push_back(seg[k]);
        in_q.push_back(8'h01);
        if (skip_carry) begin
            skip_carry = 1'b0;
            return;
        end
        while (i < seg.size() && seg[i] >= 8'h30 && seg[i] <= 8'h39) begin
            num = num * 10 + longint'(seg[i] - 8'h30);
            i++;
        end
        if (i == seg.size()) begin
            // SOH inside a tag is a bad character; skipping then eats the next field.
            exp_errs.push_back(1);
            skip_carry = 1'b1;
            return;
        end
        if (seg[i] != 8'h3D) begin
            exp_errs.push_back(1);
            return;
        end
        if (i == 0 || num > ((longint'(1) << TAG_W) - 1)) begin
            exp_errs.push_back(2);
            return;
        end
        exp_tags.push_back(int'(num));
        vlen = seg.size() - i - 1;
        if (vlen > MAXV) begin
            for (int k = 0; k < MAXV - 1; k++) begin
                b.data = seg[i+1+k]; b.last = 1'b0; b.tag = int'(num); b.len = 0;
                exp_beats.push_back(b);
            end
            exp_errs.push_back(3);
        end else begin
            for (int k = 0; k < vlen; k++) begin
                b.data = seg[i+1+k]; b.last = (k == vlen - 1); b.tag = int'(num); b.len = vlen;
                exp_beats.push_back(b);
            end
        end
    endtask

    task automatic send_field(input string s);
        logic [7:0] seg[$];
        for (int i = 0; i < s.len(); i++) seg.push_back(s[i]);
        send_seg(seg);
    endtask

    function automatic string rand_val(input int n);
        string v = "";
        for (int i = 0; i < n; i++) v = $sformatf("%s%c", v, 8'($urandom_range(32, 126)));
        return v;
    endfunction

    // One clock: sample pulses, drive inputs, check handshake beat.
    task automatic step();
        beat_t b;
        @(negedge clk);
        if (tag_valid) begin
            if (exp_tags.size() == 0) check("tag_valid_spurious", tag_valid, 0);
            else check("tag", tag, exp_tags.pop_front());
        end
        if (err) begin
            if (exp_errs.size() == 0) check("err_spurious", err, 0);
            else check("err_code", err_code, exp_errs.pop_front());
        end
        if (chk_done) begin
            if (exp_chk.size() == 0) check("chk_done_spurious", chk_done, 0);
            else check("chk_ok", chk_ok, exp_chk.pop_front());
        end
        ready  = ($urandom_range(0, 99) < ready_pct);
        enable = (in_q.size() > 0) && ($urandom_range(0, 99) < en_pct);
        din    = enable ? in_q[0] : 8'($urandom);
        #1;
        check("in_ready", in_ready, !valid || ready);
        if (valid && ready) begin
            if (exp_beats.size() == 0) begin
                check("beat_spurious", valid, 0);
            end else begin
                b = exp_beats.pop_front();
                check("dout", dout, b.data);
                check("last", last, b.last);
                check("beat_tag", tag, b.tag);
                if (b.last) check("field_len", field_len, b.len);
            end
        end
        if (enable && in_ready) void'(in_q.pop_front());
    endtask

    task automatic run_stream(input string name, input int rpct, input int epct);
        int cyc = 0;
        ready_pct = rpct;
        en_pct    = epct;
        while ((in_q.size() > 0 || exp_beats.size() > 0) && cyc < 20000) begin
            step();
            cyc++;
        end
        check("stream_drained", in_q.size() + exp_beats.size(), 0);
        ready_pct = 100;
        en_pct    = 0;
        repeat (3) step();
        check("tags_pending", exp_tags.size(), 0);
        check("errs_pending", exp_errs.size(), 0);
        check("chk_pending", exp_chk.size(), 0);
        $display("transaction %s: ready%%=%0d enable%%=%0d cycles=%0d", name, rpct, epct, cyc);
    endtask

    task automatic check_reset_values();
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_dout", dout, 0);
        check("rst_tag", tag, 0);
        check("rst_tag_valid", tag_valid, 0);
        check("rst_field_len", field_len, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_chk_done", chk_done, 0);
        check("rst_chk_ok", chk_ok, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        ready  = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset      = 1'b0;
        skip_carry = 1'b0;
    endtask

    task automatic gen_field();
        int    kind = $urandom_range(0, 11);
        int    tg   = $urandom_range(0, 65535);
        string s;
        if (tg == 10) tg = 11;
        case (kind)
            0:       s = $sformatf("%0dx=%s", tg, rand_val(2));
            1:       s = $sformatf("=%s", rand_val(2));
            2:       s = $sformatf("%0d=%s", $urandom_range(65536, 99999), rand_val(2));
            3:       s = $sformatf("%0d=", tg);
            4:       s = $sformatf("%0d=%s", tg, rand_val(MAXV + 1 + $urandom_range(0, 2)));
            5:       s = $sformatf("%0d", tg);
            default: s = $sformatf("%0d=%s", tg, rand_val($urandom_range(1, MAXV)));
        endcase
        send_field(s);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        din    = 8'h00;
        ready  = 1'b1;
        do_reset();

`ifdef FIX_CHECKSUM_EN
        begin
            string pre = "8=A";
            int    sum = 1;
            for (int i = 0; i < pre.len(); i++) sum += pre[i];
            sum = sum % 256;
            send_field(pre);
            send_field($sformatf("10=%03d", sum));
            exp_chk.push_back(1);
            send_field(pre);
            send_field($sformatf("10=%03d", (sum + 1) % 256));
            exp_chk.push_back(0);
            run_stream("checksum", 100, 100);
        end
`endif

        send_field("35=A");
        run_stream("single_byte", 100, 100);
        send_field("49=ABC");
        run_stream("stalled_value", 25, 100);
        send_field("3x=1");
        send_field("8=F");
        run_stream("bad_tag_char", 100, 100);
        send_field("58=ABCDE");
        send_field("8=F");
        run_stream("value_overflow", 60, 100);
        send_field("7=");
        send_field("=AB");
        send_field("65535=Q");
        send_field("65536=Q");
        send_field("12=WXYZ");
        send_field("123");
        send_field("4=swallowed");
        send_field("5=ok");
        run_stream("boundaries", 50, 70);

        // Reset in the middle of a value: held byte must vanish.
        in_q.push_back("5"); in_q.push_back("5"); in_q.push_back("="); in_q.push_back("X");
        exp_tags.push_back(55);
        ready_pct = 100;
        en_pct    = 100;
        while (in_q.size() > 0) step();
        check("tag55_seen", exp_tags.size(), 0);
        do_reset();
        send_field("9=Z");
        run_stream("after_reset", 100, 100);

        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < 40; f++) gen_field();
            run_stream($sformatf("random_%0d", r), 20 + 25 * r, 40 + 20 * r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fix_field_parser.md
FIX_FIELD_PARSER -- requirements
Module: fix_field_parser

Interface
REQ-001 Parameter TAG_W, default 16: width of the binary tag number.
REQ-002 Parameter MAX_VAL_LEN, default 32: maximum value bytes per field; more is an error.
REQ-003 Parameter LEN_W, default 8: width of field_len; MAX_VAL_LEN SHALL be < 2**LEN_W.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  din valid; a byte is accepted when enable && in_ready.
REQ-007 din  input  8  ASCII FIX byte stream.
REQ-008 ready  input  1  downstream accepts dout when valid && ready.
REQ-009 in_ready  output  1  parser can accept din.
REQ-010 dout  output  8  value byte.
REQ-011 valid  output  1  dout holds a value byte.
REQ-012 last  output  1  dout is the final byte of its field value.
REQ-013 tag  output  TAG_W  binary tag of the current field; stable while valid.
REQ-014 tag_valid  output  1  one-cycle pulse: tag decoded.
REQ-015 field_len  output  LEN_W  value byte count; meaningful while valid && last.
REQ-016 err  output  1  one-cycle error pulse.
REQ-017 err_code  output  2  1=bad tag char, 2=empty or overflowed tag, 3=value over MAX_VAL_LEN, 0 otherwise.
REQ-018 chk_done, chk_ok  output  1 each  checksum result pulse and pass flag.

Function
REQ-019 Field format: tag digits '0'-'9', then '=' (0x3D), then value bytes, then SOH (0x01).
REQ-020 FSM states: TAG, VALUE, SKIP; reset state is TAG.
REQ-021 TAG: each digit updates tag_acc = tag_acc*10 + digit.
  - '=' with >=1 digit and no overflow -> VALUE; tag <= tag_acc; tag_valid pulses the next cycle.
REQ-022 TAG errors, each -> err_code and SKIP:
  - any other byte, SOH included -> err_code 1;
  - '=' with zero digits, or tag_acc exceeding 2**TAG_W-1 -> err_code 2.
REQ-023 VALUE: each non-SOH byte is loaded into a one-entry hold register and the length counter increments.
  - The held byte is presented on dout (valid=1, last=0) when the next value byte is accepted.
  - It is presented with last=1 when SOH is accepted; then -> TAG.
REQ-024 Output latency: one cycle after the successor byte or SOH is accepted.
REQ-025 Empty value ("n=" followed directly by SOH): no beat is emitted, err=0, -> TAG.
REQ-026 Value byte number MAX_VAL_LEN+1: pulse err with err_code 3, drop the byte and the held byte, -> SKIP.
REQ-027 SKIP: discard bytes until SOH is accepted, then -> TAG; no beats emitted.
REQ-028 in_ready = !valid || ready; dout, last, tag and field_len SHALL hold while valid && !ready.
REQ-029 The output register and the hold register together guarantee zero byte loss under arbitrary ready patterns.
REQ-030 Simultaneous err and a final beat (SOH accepted) cannot occur; an error never emits a last beat.

Reset
REQ-031 reset wins over all other inputs in the same cycle.
REQ-032 Reset values: state=TAG, valid=0, last=0, dout=0, tag=0, tag_valid=0, field_len=0, err=0, err_code=0, chk_done=0, chk_ok=0, counters and accumulators 0.
REQ-033 Reset mid-field discards held and output bytes with no trailing beat; parsing restarts at the next byte as a tag.

Configuration
REQ-034 Macro FIX_CHECKSUM_EN.
  - Defined: a running mod-256 sum covers every accepted byte.
  - On the first byte of each field, the sum of all prior bytes is snapshotted.
  - For tag 10, the value digits are accumulated in decimal.
  - On its SOH: chk_done pulses with the last beat, and chk_ok=1 iff the value equals the snapshot.
  - The sum resets after tag 10.
REQ-035 FIX_CHECKSUM_EN undefined: the checksum logic is absent and chk_done and chk_ok are tied to 0.

Verification
REQ-036 Stream "35=A<SOH>" with ready=1 -> tag_valid with tag=35; one beat dout=0x41, last=1, field_len=1.
REQ-037 "49=ABC<SOH>" with ready low for 3 cycles mid-value -> beats A, B, C in order; last on C only; no loss; in_ready=0 while stalled.
REQ-038 "3x=1<SOH>8=F<SOH>" -> err pulse, err_code=1, no beats for the first field; the second field gives tag=8, dout=0x46, last=1.
REQ-039 MAX_VAL_LEN=4 with "58=ABCDE<SOH>" -> beats A, B, C; err_code=3 on E; no last beat; the next field parses normally.
REQ-040 FIX_CHECKSUM_EN defined, with "8=A<SOH>10=<correct 3 digits><SOH>" -> chk_done=1, chk_ok=1; one digit corrupted -> chk_ok=0.
REQ-041 reset asserted during "55=XY" after X is accepted -> all outputs at reset values the next cycle; "9=Z<SOH>" afterwards -> tag=9, dout=0x5A, last=1.
